// File: rtl/cpu_eu_param.sv
// Execution unit: FETCH/DECODE/MEM/HALT sequencer driving one memory port; optional perf counter via CPU_EU_PERF_CNT_EN.
// Latency: fetch and mem ops complete on the ack edge (zero-wait capable); retire pulse follows one cycle later.
// Backpressure: memory requests hold address/data until mem_ack; DECODE stalls indefinitely for op_valid.
module cpu_eu_param #(
    parameter int              DW     = 16,
    parameter int              OFFW   = 8,
    parameter logic [DW-1:0]   RST_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    input  logic          op_valid,
    input  logic [2:0]    op_kind,
    input  logic          cond,
    input  logic [DW-1:0] alu_out,
    input  logic [DW-1:0] reg_out,
    output logic [DW-1:0] ir_out,
    output logic          ir_valid,
    output logic [DW-1:0] pc_out,
    output logic [DW-1:0] wb_data,
    output logic          wb_valid,
    output logic          op_done,
    output logic          halted,
    output logic [31:0]   instr_cnt
);

    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_JREL  = 3'd3;
    localparam logic [2:0] OP_JABS  = 3'd4;
    localparam logic [2:0] OP_BREL  = 3'd5;
    localparam logic [2:0] OP_HALT  = 3'd6;

    typedef enum logic [1:0] {FETCH, DECODE, MEM, HALT} state_t;

    state_t        state, state_nxt;
    logic          retire;
    logic [DW-1:0] rel_off;

    assign rel_off  = DW'($signed(ir_out[OFFW-1:0]));
    assign ir_valid = (state == DECODE);
    assign halted   = (state == HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            FETCH: begin
                if (mem_req && mem_ack) state_nxt = DECODE;
            end
            DECODE: begin
                if (op_valid) begin
                    case (op_kind)
                        OP_LOAD, OP_STORE: state_nxt = MEM;
                        OP_HALT: begin
                            state_nxt = HALT;
                            retire    = 1'b1;
                        end
                        default: begin
                            state_nxt = FETCH;
                            retire    = 1'b1;
                        end
                    endcase
                end
            end
            MEM: begin
                if (mem_req && mem_ack) begin
                    state_nxt = FETCH;
                    retire    = 1'b1;
                end
            end
            default: state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ir_out    <= '0;
            pc_out    <= RST_PC;
            wb_data   <= '0;
            wb_valid  <= 1'b0;
            op_done   <= 1'b0;
        end else begin
            op_done  <= retire;
            wb_valid <= 1'b0;
            case (state)
                FETCH: begin
                    // request raised one edge after entering FETCH, so ack while idle is never seen
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc_out;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        ir_out  <= mem_rdata;
                        pc_out  <= pc_out + DW'(1);
                    end
                end
                DECODE: begin
                    if (op_valid) begin
                        case (op_kind)
                            OP_LOAD: begin
                                mem_req  <= 1'b1;
                                mem_we   <= 1'b0;
                                mem_addr <= reg_out;
                            end
                            OP_STORE: begin
                                mem_req   <= 1'b1;
                                mem_we    <= 1'b1;
                                mem_addr  <= reg_out;
                                mem_wdata <= alu_out;
                            end
                            OP_JREL: pc_out <= pc_out + rel_off;
                            OP_JABS: pc_out <= alu_out;
                            OP_BREL: if (cond) pc_out <= pc_out + rel_off;
                            default: ;
                        endcase
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!mem_we) begin
                            wb_data  <= mem_rdata;
                            wb_valid <= 1'b1;
                        end
                    end
                end
                default: mem_req <= 1'b0;
            endcase
        end
    end

`ifdef CPU_EU_PERF_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       cnt_q <= '0;
        else if (op_done) cnt_q <= cnt_q + 32'd1;
    end

    assign instr_cnt = cnt_q;
`else
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_eu_param.sv
// Bench for cpu_eu_param (DW=16, OFFW=8, RST_PC=0x0010): directed table, randomized ops vs. model, reset and halt sequences.
module tb_cpu_eu_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        op_valid;
    logic [2:0]  op_kind;
    logic        cond;
    logic [15:0] alu_out, reg_out;
    logic [15:0] ir_out, pc_out, wb_data;
    logic        ir_valid, wb_valid, op_done, halted;
    logic [31:0] instr_cnt;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_pc, m_ir, m_wb;
    int          m_cnt;

    cpu_eu_param #(.DW(16), .OFFW(8), .RST_PC(16'h0010)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .op_valid(op_valid), .op_kind(op_kind), .cond(cond),
        .alu_out(alu_out), .reg_out(reg_out),
        .ir_out(ir_out), .ir_valid(ir_valid), .pc_out(pc_out),
        .wb_data(wb_data), .wb_valid(wb_valid),
        .op_done(op_done), .halted(halted), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] ir;
        int          fdly;
        logic [2:0]  kind;
        logic        cnd;
        logic [15:0] alu;
        logic [15:0] regv;
        logic [15:0] rdata;
        int          mdly;
        logic [15:0] exp_pc;
        logic [15:0] exp_wb;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef CPU_EU_PERF_CNT_EN
        return 32'(m_cnt);
`else
        return 32'd0;
`endif
    endfunction

    // Reference next-PC: relative offset is the signed low byte of the instruction
    function automatic logic [15:0] model_pc(input logic [2:0] k, input logic c, input logic [15:0] a);
        int off;
        int s;
        off = int'(m_ir[7:0]);
        if (off > 127) off -= 256;
        s = (int'(m_pc) + off) & 32'hFFFF;
        case (k)
            3'd3:    return s[15:0];
            3'd4:    return a;
            3'd5:    return c ? s[15:0] : m_pc;
            default: return m_pc;
        endcase
    endfunction

    task automatic fetch(input logic [15:0] data, input int dly);
        int n = 0;
        while (!mem_req && n < 20) begin
            op_valid = 1'($urandom_range(0, 1));
            op_kind  = 3'd4;
            alu_out  = 16'($urandom);
            tick();
            n++;
        end
        check("fetch_req", {31'd0, mem_req}, 32'd1);
        check("fetch_addr", {16'd0, mem_addr}, {16'd0, m_pc});
        check("fetch_we", {31'd0, mem_we}, 32'd0);
        for (int i = 0; i < dly; i++) begin
            tick();
            check("fetch_hold", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, m_pc});
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack  = 1'b0;
        op_valid = 1'b0;
        m_ir     = data;
        m_pc     = m_pc + 16'd1;
        check("fetch_ir", {16'd0, ir_out}, {16'd0, m_ir});
        check("fetch_pc", {16'd0, pc_out}, {16'd0, m_pc});
        check("fetch_irv", {30'd0, ir_valid, mem_req}, {30'd0, 1'b1, 1'b0});
    endtask

    task automatic exec(input logic [2:0] k, input logic c, input logic [15:0] a,
                        input logic [15:0] r, input logic [15:0] rd, input int dly,
                        input logic [15:0] exp_pc);
        int idle;
        idle = int'($urandom_range(0, 2));
        for (int i = 0; i < idle; i++) begin
            tick();
            check("decode_wait", {31'd0, ir_valid}, 32'd1);
        end
        check("decode_irv", {31'd0, ir_valid}, 32'd1);
        op_valid = 1'b1;
        op_kind  = k;
        cond     = c;
        alu_out  = a;
        reg_out  = r;
        tick();
        op_valid = 1'b0;
        op_kind  = 3'($urandom);
        alu_out  = 16'($urandom);
        reg_out  = 16'($urandom);
        if (k == 3'd1 || k == 3'd2) begin
            check("mem_req", {31'd0, mem_req}, 32'd1);
            check("mem_addr", {16'd0, mem_addr}, {16'd0, r});
            check("mem_we", {31'd0, mem_we}, {31'd0, k == 3'd2});
            if (k == 3'd2) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, a});
            for (int i = 0; i < dly; i++) begin
                tick();
                check("mem_hold", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, r});
            end
            mem_ack   = 1'b1;
            mem_rdata = rd;
            tick();
            mem_ack = 1'b0;
        end
        m_pc = exp_pc;
        m_cnt++;
        if (k == 3'd1) m_wb = rd;
        check("op_done", {31'd0, op_done}, 32'd1);
        check("pc", {16'd0, pc_out}, {16'd0, m_pc});
        check("wb_valid", {31'd0, wb_valid}, {31'd0, k == 3'd1});
        check("wb_data", {16'd0, wb_data}, {16'd0, m_wb});
        check("halted", {31'd0, halted}, {31'd0, k == 3'd6});
        tick();
        check("op_done_pulse", {30'd0, op_done, wb_valid}, 32'd0);
        check("instr_cnt", instr_cnt, exp_cnt());
    endtask

    vec_t vt[11];

    initial begin
        logic [2:0]  k;
        logic        c;
        logic [15:0] a, r, rd, ir;

        vt[0]  = '{16'h1234, 0, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0011, 16'h0000};
        vt[1]  = '{16'h0000, 1, 3'd4, 1'b0, 16'h0020, 16'h0000, 16'h0000, 0, 16'h0020, 16'h0000};
        vt[2]  = '{16'h12FE, 0, 3'd5, 1'b1, 16'h0000, 16'h0000, 16'h0000, 0, 16'h001F, 16'h0000};
        vt[3]  = '{16'h0000, 2, 3'd4, 1'b0, 16'h0020, 16'h0000, 16'h0000, 0, 16'h0020, 16'h0000};
        vt[4]  = '{16'h12FE, 0, 3'd5, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0021, 16'h0000};
        vt[5]  = '{16'h0000, 0, 3'd1, 1'b0, 16'h0000, 16'h8000, 16'hBEEF, 3, 16'h0022, 16'hBEEF};
        vt[6]  = '{16'h0000, 0, 3'd4, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'hBEEF};
        vt[7]  = '{16'h0005, 1, 3'd3, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0005, 16'hBEEF};
        vt[8]  = '{16'h0000, 0, 3'd4, 1'b0, 16'h0300, 16'h0000, 16'h0000, 0, 16'h0300, 16'hBEEF};
        vt[9]  = '{16'h0000, 2, 3'd2, 1'b0, 16'h5A5A, 16'h0040, 16'h0000, 2, 16'h0301, 16'hBEEF};
        vt[10] = '{16'h0080, 0, 3'd3, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0282, 16'hBEEF};

        reset = 1'b0; mem_ack = 1'b0; mem_rdata = '0; op_valid = 1'b0; op_kind = '0;
        cond = 1'b0; alu_out = '0; reg_out = '0;
        m_pc = 16'h0010; m_ir = '0; m_wb = '0; m_cnt = 0;
        tick(); tick();
        check("rst_pc", {16'd0, pc_out}, 32'h0010);
        check("rst_ir", {16'd0, ir_out}, 32'd0);
        check("rst_mem", {14'd0, mem_req, mem_we, mem_addr}, 32'd0);
        check("rst_strb", {28'd0, op_done, wb_valid, halted, ir_valid}, 32'd0);
        check("rst_wb", {16'd0, wb_data}, 32'd0);
        check("rst_cnt", instr_cnt, 32'd0);
        reset = 1'b1;
        tick();
        check("first_req", {31'd0, mem_req}, 32'd1);

        for (int i = 0; i < 11; i++) begin
            fetch(vt[i].ir, vt[i].fdly);
            exec(vt[i].kind, vt[i].cnd, vt[i].alu, vt[i].regv, vt[i].rdata, vt[i].mdly, vt[i].exp_pc);
            check("tbl_wb", {16'd0, wb_data}, {16'd0, vt[i].exp_wb});
        end

        for (int i = 0; i < 60; i++) begin
            k  = 3'($urandom_range(0, 6));
            if (k == 3'd6) k = 3'd7;
            c  = 1'($urandom);
            a  = 16'($urandom);
            r  = 16'($urandom);
            rd = 16'($urandom);
            ir = 16'($urandom);
            fetch(ir, int'($urandom_range(0, 3)));
            exec(k, c, a, r, rd, int'($urandom_range(0, 3)), model_pc(k, c, a));
        end

        // reset while a store waits for its ack
        fetch(16'h0000, 0);
        op_valid = 1'b1; op_kind = 3'd2; reg_out = 16'h0040; alu_out = 16'h5A5A;
        tick();
        op_valid = 1'b0;
        check("st_we", {15'd0, mem_req, mem_we, mem_wdata}, {15'd0, 1'b1, 1'b1, 16'h5A5A});
        tick();
        reset = 1'b0;
        #1;
        check("rst_mid_req", {30'd0, mem_req, mem_we}, 32'd0);
        check("rst_mid_pc", {16'd0, pc_out}, 32'h0010);
        check("rst_mid_cnt", instr_cnt, 32'd0);
        m_pc = 16'h0010; m_ir = '0; m_wb = '0; m_cnt = 0;
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        reset = 1'b1;
        tick();
        check("rst_stray_ack", {15'd0, mem_req, ir_out}, {15'd0, 1'b1, 16'h0000});
        mem_ack = 1'b0;

        for (int i = 0; i < 5; i++) begin
            k = 3'($urandom_range(0, 5));
            c = 1'($urandom);
            a = 16'($urandom);
            r = 16'($urandom);
            rd = 16'($urandom);
            fetch(16'($urandom), int'($urandom_range(0, 2)));
            exec(k, c, a, r, rd, int'($urandom_range(0, 2)), model_pc(k, c, a));
        end
        fetch(16'h0000, 0);
        exec(3'd6, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, m_pc);
        for (int i = 0; i < 10; i++) begin
            op_valid = 1'($urandom);
            op_kind  = 3'd4;
            alu_out  = 16'($urandom);
            mem_ack  = 1'($urandom);
            tick();
            check("halt_hold", {14'd0, halted, mem_req, pc_out}, {14'd0, 1'b1, 1'b0, m_pc});
            check("halt_done", {31'd0, op_done}, 32'd0);
        end
        op_valid = 1'b0; mem_ack = 1'b0;
`ifdef CPU_EU_PERF_CNT_EN
        check("halt_cnt", instr_cnt, 32'd6);
`else
        check("halt_cnt", instr_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
